status_cond_unit: RTL and testbench
===================================

STATUS_COND_UNIT -- requirements
Module: status_cond_unit

Interface
REQ-001 Parameter: STACK_DEPTH, default 4, number of saved-status entries (min 2).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 flag_valid  input  1  capture ALU flags this cycle.
REQ-005 zero_in, carry_in, overflow_in, negative_in  input  1 each  ALU status flags.
REQ-006 sr_we  input  1  direct write of status register.
REQ-007 sr_wdata  input  4  write data, bit order {N,Z,C,V}.
REQ-008 push  input  1  save current SR to stack.
REQ-009 pop  input  1  restore SR from stack top.
REQ-010 err_clr  input  1  clears stack_err.
REQ-011 cond_valid  input  1  condition evaluation request.
REQ-012 cond_code  input  4  condition selector.
REQ-013 sr  output  4  status register {N,Z,C,V}.
REQ-014 cond_result_valid  output  1  one-cycle pulse, result available.
REQ-015 cond_taken  output  1  condition evaluation result.
REQ-016 stack_full, stack_empty  output  1 each  stack occupancy.
REQ-017 stack_err  output  1  sticky overflow/underflow indicator.

Function
REQ-018 SR next-value priority: valid pop > sr_we > flag_valid > hold.
REQ-019 flag_valid capture loads {negative_in, zero_in, carry_in, overflow_in} unmodified.
REQ-020 Valid push (push=1, pop=0, not full) writes pre-update SR at count index, count+1; same-cycle sr_we/flag_valid still update SR.
REQ-021 Valid pop (pop=1, push=0, not empty) loads SR from entry count-1, count-1.
REQ-022 push and pop asserted together: stack and count unchanged, no error; SR follows sr_we/flag_valid.
REQ-023 push when full: ignored, stack_err set; pop when empty: ignored, stack_err set, SR follows lower-priority sources.
REQ-024 stack_err stays set until err_clr or reset; set condition in same cycle as err_clr wins (remains 1).
REQ-025 stack_full = (count == STACK_DEPTH); stack_empty = (count == 0); count width ceil(log2(STACK_DEPTH+1)).
REQ-026 Condition evaluated on SR value before this cycle's update; result registered, latency 1 cycle.
REQ-027 cond_result_valid = cond_valid delayed one cycle; cond_taken updates only when cond_valid=1, else holds.
REQ-028 Codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
REQ-029 Codes: 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V); 14 AL 1; 15 NV 0.
REQ-030 Back-to-back cond_valid accepted every cycle, one result per request, no stall.

Reset
REQ-031 rst_n low asynchronously forces sr=0, count=0, stack_err=0, cond_result_valid=0, cond_taken=0; stack_empty=1, stack_full=0.
REQ-032 Stack entry contents need no reset; never readable while empty.
REQ-033 Reset mid-operation discards pending condition result; first edge after release behaves as idle state.

Verification
REQ-034 flag_valid with Z=1,others 0 -> sr=4'b0100 next cycle; cond_code=0 next cycle -> cond_taken=1, cond_result_valid pulse 1 cycle later.
REQ-035 sr=4'b1001 (N=1,V=1): codes 10,11,12,13 -> taken 1,0,1,0.
REQ-036 Push sr=4'hA, sr_we 4'h3, pop -> sr=4'hA, stack_empty=1, stack_err=0.
REQ-037 STACK_DEPTH+1 pushes -> stack_full=1 after 4th, 5th sets stack_err; pop on empty after drain keeps stack_err=1 until err_clr.
REQ-038 Same cycle: pop, sr_we=4'hF, flag_valid, cond_valid code 14 -> sr=popped value, cond_taken=1; push+pop together -> count unchanged.
REQ-039 rst_n asserted between cond_valid and result -> no cond_result_valid pulse, all outputs at reset values.

Source files
------------

// File: rtl/status_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : status_cond_unit
// Purpose  : Processor status register {N,Z,C,V} with a small save/restore
//            stack and a registered 16-way branch-condition evaluator.
// Ports    :
//   clk, rst_n                    clock, asynchronous active-low reset
//   flag_valid                    load ALU flags into SR this cycle
//   negative_in/zero_in/
//   carry_in/overflow_in          ALU flags
//   sr_we, sr_wdata[3:0]          direct SR write, bit order {N,Z,C,V}
//   push, pop                     save SR to / restore SR from the stack
//   err_clr                       clear the sticky stack_err flag
//   cond_valid, cond_code[3:0]    condition evaluation request
//   sr[3:0]                       current status register
//   cond_result_valid, cond_taken condition result, one cycle after request
//   stack_full, stack_empty       stack occupancy
//   stack_err                     sticky overflow/underflow indicator
// Revision : 1.0 - initial release
// ============================================================================
module status_cond_unit #(
    parameter int STACK_DEPTH = 4   // saved-status entries, must be >= 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flag_valid,
    input  logic       zero_in,
    input  logic       carry_in,
    input  logic       overflow_in,
    input  logic       negative_in,
    input  logic       sr_we,
    input  logic [3:0] sr_wdata,
    input  logic       push,
    input  logic       pop,
    input  logic       err_clr,
    input  logic       cond_valid,
    input  logic [3:0] cond_code,
    output logic [3:0] sr,
    output logic       cond_result_valid,
    output logic       cond_taken,
    output logic       stack_full,
    output logic       stack_empty,
    output logic       stack_err
);

    // Occupancy must represent 0..STACK_DEPTH; entry index only 0..STACK_DEPTH-1.
    localparam int c_cnt_w = $clog2(STACK_DEPTH + 1);
    localparam int c_idx_w = $clog2(STACK_DEPTH);

    logic [3:0]         r_sr;
    logic [c_cnt_w-1:0] r_count;
    logic [3:0]         r_stack [STACK_DEPTH];
    logic               r_stack_err;
    logic               r_cond_rv;
    logic               r_cond_taken;

    logic               w_full;
    logic               w_empty;
    logic               w_push_ok;
    logic               w_pop_ok;
    logic               w_err_set;
    logic               w_cond;
    logic [c_idx_w-1:0] w_push_idx;
    logic [c_idx_w-1:0] w_pop_idx;
    logic [3:0]         w_sr_next;
    logic [c_cnt_w-1:0] w_count_next;
    logic               w_n, w_z, w_c, w_v;

    assign w_full  = (r_count == c_cnt_w'(STACK_DEPTH));
    assign w_empty = (r_count == '0);

    // push and pop together cancel out: neither acts and no error is raised.
    assign w_push_ok = push & ~pop & ~w_full;
    assign w_pop_ok  = pop & ~push & ~w_empty;
    assign w_err_set = (push & ~pop & w_full) | (pop & ~push & w_empty);

    // Index truncation is safe: a push only happens below full and a pop
    // only above empty, so the dropped bits are always zero.
    assign w_push_idx = c_idx_w'(r_count);
    assign w_pop_idx  = c_idx_w'(r_count - c_cnt_w'(1));

    // SR source priority: stack restore, direct write, ALU flags, hold.
    always_comb begin
        w_sr_next = r_sr;
        if (w_pop_ok) begin
            w_sr_next = r_stack[w_pop_idx];
        end else if (sr_we) begin
            w_sr_next = sr_wdata;
        end else if (flag_valid) begin
            w_sr_next = {negative_in, zero_in, carry_in, overflow_in};
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push_ok) begin
            w_count_next = r_count + c_cnt_w'(1);
        end else if (w_pop_ok) begin
            w_count_next = r_count - c_cnt_w'(1);
        end
    end

    // Conditions look at the SR as it stood before this cycle's update.
    assign w_n = r_sr[3];
    assign w_z = r_sr[2];
    assign w_c = r_sr[1];
    assign w_v = r_sr[0];

    always_comb begin
        w_cond = 1'b0;
        case (cond_code)
            4'd0:  w_cond = w_z;                      // EQ
            4'd1:  w_cond = ~w_z;                     // NE
            4'd2:  w_cond = w_c;                      // CS
            4'd3:  w_cond = ~w_c;                     // CC
            4'd4:  w_cond = w_n;                      // MI
            4'd5:  w_cond = ~w_n;                     // PL
            4'd6:  w_cond = w_v;                      // VS
            4'd7:  w_cond = ~w_v;                     // VC
            4'd8:  w_cond = w_c & ~w_z;               // HI
            4'd9:  w_cond = ~w_c | w_z;               // LS
            4'd10: w_cond = (w_n == w_v);             // GE
            4'd11: w_cond = (w_n != w_v);             // LT
            4'd12: w_cond = ~w_z & (w_n == w_v);      // GT
            4'd13: w_cond = w_z | (w_n != w_v);       // LE
            4'd14: w_cond = 1'b1;                     // AL
            default: w_cond = 1'b0;                   // NV
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr         <= 4'h0;
            r_count      <= '0;
            r_stack_err  <= 1'b0;
            r_cond_rv    <= 1'b0;
            r_cond_taken <= 1'b0;
        end else begin
            r_sr      <= w_sr_next;
            r_count   <= w_count_next;
            r_cond_rv <= cond_valid;
            if (cond_valid) begin
                r_cond_taken <= w_cond;
            end
            // A fresh error in the same cycle as a clear keeps the flag set.
            if (w_err_set) begin
                r_stack_err <= 1'b1;
            end else if (err_clr) begin
                r_stack_err <= 1'b0;
            end
        end
    end

    // Entry storage is never read while empty, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_stack[w_push_idx] <= r_sr;
        end
    end

    assign sr                = r_sr;
    assign cond_result_valid = r_cond_rv;
    assign cond_taken        = r_cond_taken;
    assign stack_full        = w_full;
    assign stack_empty       = w_empty;
    assign stack_err         = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_status_cond_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_status_cond_unit
// Purpose  : Self-checking bench for status_cond_unit. A queue-based model
//            tracks SR, stack and condition result; a compare process checks
//            every DUT output against it on each falling clock edge, and
//            directed sequences pin the model with hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_status_cond_unit;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag_valid, zero_in, carry_in, overflow_in, negative_in;
    logic       sr_we;
    logic [3:0] sr_wdata;
    logic       push, pop, err_clr;
    logic       cond_valid;
    logic [3:0] cond_code;
    logic [3:0] sr;
    logic       cond_result_valid, cond_taken;
    logic       stack_full, stack_empty, stack_err;

    int n_total = 0;
    int n_pass  = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    status_cond_unit #(.STACK_DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flag_valid        (flag_valid),
        .zero_in           (zero_in),
        .carry_in          (carry_in),
        .overflow_in       (overflow_in),
        .negative_in       (negative_in),
        .sr_we             (sr_we),
        .sr_wdata          (sr_wdata),
        .push              (push),
        .pop               (pop),
        .err_clr           (err_clr),
        .cond_valid        (cond_valid),
        .cond_code         (cond_code),
        .sr                (sr),
        .cond_result_valid (cond_result_valid),
        .cond_taken        (cond_taken),
        .stack_full        (stack_full),
        .stack_empty       (stack_empty),
        .stack_err         (stack_err)
    );

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    logic [3:0] m_sr    = 4'h0;
    logic [3:0] m_q[$];
    logic       m_err   = 1'b0;
    logic       m_crv   = 1'b0;
    logic       m_taken = 1'b0;
    logic [3:0] t_old;
    logic       t_full, t_empty, t_push_ok, t_pop_ok;

    // Conditions come in complementary pairs: odd codes invert the even one.
    function automatic logic eval_cond(input logic [3:0] s, input logic [3:0] code);
        logic n, z, c, v, base;
        n = s[3]; z = s[2]; c = s[1]; v = s[0];
        case (code[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ code[0];
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_sr = 4'h0; m_q.delete(); m_err = 1'b0; m_crv = 1'b0; m_taken = 1'b0;
        end else begin
            t_old     = m_sr;
            t_full    = (m_q.size() == DEPTH);
            t_empty   = (m_q.size() == 0);
            t_push_ok = push && !pop && !t_full;
            t_pop_ok  = pop && !push && !t_empty;
            m_crv = cond_valid;
            if (cond_valid) m_taken = eval_cond(t_old, cond_code);
            if ((push && !pop && t_full) || (pop && !push && t_empty)) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (t_pop_ok)        m_sr = m_q.pop_back();
            else if (sr_we)      m_sr = sr_wdata;
            else if (flag_valid) m_sr = {negative_in, zero_in, carry_in, overflow_in};
            if (t_push_ok) m_q.push_back(t_old);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Compare process: every output against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (chk_on) begin
            chk("sr",         8'(sr),                8'(m_sr));
            chk("full",       8'(stack_full),        8'(m_q.size() == DEPTH));
            chk("empty",      8'(stack_empty),       8'(m_q.size() == 0));
            chk("err",        8'(stack_err),         8'(m_err));
            chk("cond_rv",    8'(cond_result_valid), 8'(m_crv));
            chk("cond_taken", 8'(cond_taken),        8'(m_taken));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        flag_valid = 0; zero_in = 0; carry_in = 0; overflow_in = 0; negative_in = 0;
        sr_we = 0; sr_wdata = 4'h0; push = 0; pop = 0; err_clr = 0;
        cond_valid = 0; cond_code = 4'h0;
    endtask

    task automatic write_sr(input logic [3:0] v);
        clr_in(); sr_we = 1; sr_wdata = v; tick(); clr_in();
    endtask

    int         codes[6]   = '{10, 11, 12, 13, 14, 15};
    logic       exp_tk[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] pop_exp[4] = '{4'h3, 4'h2, 4'h1, 4'hA};
    logic [3:0] sweep[8]   = '{4'h0, 4'hF, 4'h5, 4'hA, 4'h3, 4'hC, 4'h8, 4'h4};

    initial begin
        rst_n = 1'b0;
        clr_in();
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Reset state
        chk("rst_sr", 8'(sr), 8'h0);
        chk("rst_empty", 8'(stack_empty), 8'h1);
        chk("rst_full", 8'(stack_full), 8'h0);
        chk("rst_err", 8'(stack_err), 8'h0);
        chk("rst_crv", 8'(cond_result_valid), 8'h0);
        chk("rst_taken", 8'(cond_taken), 8'h0);

        // Zero flag capture then EQ
        flag_valid = 1; zero_in = 1; tick();
        chk("flag_z_sr", 8'(sr), 8'h4);
        clr_in(); cond_valid = 1; cond_code = 4'd0; tick();
        chk("eq_taken", 8'(cond_taken), 8'h1);
        chk("eq_crv", 8'(cond_result_valid), 8'h1);
        clr_in(); tick();
        chk("eq_crv_drop", 8'(cond_result_valid), 8'h0);
        chk("eq_taken_hold", 8'(cond_taken), 8'h1);

        // Flag bit ordering {N,Z,C,V}
        for (int f = 0; f < 16; f++) begin
            clr_in(); flag_valid = 1;
            {negative_in, zero_in, carry_in, overflow_in} = 4'(f);
            tick();
            chk("flag_order", 8'(sr), 8'(f));
        end
        clr_in();

        // Signed comparisons on N=1,V=1, back-to-back
        write_sr(4'h9);
        chk("sr_we_9", 8'(sr), 8'h9);
        for (int i = 0; i < 6; i++) begin
            cond_valid = 1; cond_code = 4'(codes[i]); tick();
            chk("signed_cond", 8'(cond_taken), 8'(exp_tk[i]));
            chk("signed_crv", 8'(cond_result_valid), 8'h1);
        end
        clr_in();

        // Push, overwrite, pop restores
        write_sr(4'hA);
        push = 1; tick(); clr_in();
        chk("push1_empty", 8'(stack_empty), 8'h0);
        write_sr(4'h3);
        chk("sr_we_3", 8'(sr), 8'h3);
        pop = 1; tick(); clr_in();
        chk("pop_sr", 8'(sr), 8'hA);
        chk("pop_empty", 8'(stack_empty), 8'h1);
        chk("pop_err", 8'(stack_err), 8'h0);

        // Overflow: DEPTH+1 pushes, same-cycle writes still update SR
        for (int i = 0; i < DEPTH + 1; i++) begin
            push = 1; sr_we = 1; sr_wdata = 4'(i + 1); tick();
            if (i == DEPTH - 1) begin
                chk("fill_full", 8'(stack_full), 8'h1);
                chk("fill_err0", 8'(stack_err), 8'h0);
            end
        end
        clr_in();
        chk("ovf_err", 8'(stack_err), 8'h1);
        chk("ovf_sr", 8'(sr), 8'h5);
        for (int i = 0; i < DEPTH; i++) begin
            pop = 1; tick();
            chk("drain_sr", 8'(sr), 8'(pop_exp[i]));
        end
        clr_in();
        chk("drain_empty", 8'(stack_empty), 8'h1);
        chk("drain_err", 8'(stack_err), 8'h1);
        pop = 1; sr_we = 1; sr_wdata = 4'h7; tick(); clr_in();
        chk("udf_sr", 8'(sr), 8'h7);
        chk("udf_err", 8'(stack_err), 8'h1);
        pop = 1; err_clr = 1; tick(); clr_in();
        chk("set_beats_clr", 8'(stack_err), 8'h1);
        err_clr = 1; tick(); clr_in();
        chk("err_clr", 8'(stack_err), 8'h0);

        // Pop beats sr_we and flags; AL same cycle
        write_sr(4'h6);
        push = 1; tick(); clr_in();
        pop = 1; sr_we = 1; sr_wdata = 4'hF; flag_valid = 1; negative_in = 1;
        cond_valid = 1; cond_code = 4'd14; tick(); clr_in();
        chk("prio_sr", 8'(sr), 8'h6);
        chk("prio_taken", 8'(cond_taken), 8'h1);
        chk("prio_empty", 8'(stack_empty), 8'h1);
        push = 1; sr_we = 1; sr_wdata = 4'h2; tick(); clr_in();
        chk("push_we_sr", 8'(sr), 8'h2);
        push = 1; pop = 1; sr_we = 1; sr_wdata = 4'hC; tick(); clr_in();
        chk("pp_sr", 8'(sr), 8'hC);
        chk("pp_empty", 8'(stack_empty), 8'h0);
        chk("pp_err", 8'(stack_err), 8'h0);
        pop = 1; tick(); clr_in();
        chk("pp_pop_sr", 8'(sr), 8'h6);
        chk("pp_pop_empty", 8'(stack_empty), 8'h1);

        // All codes over a set of SR values (model-checked)
        for (int s = 0; s < 8; s++) begin
            write_sr(sweep[s]);
            for (int c = 0; c < 16; c++) begin
                cond_valid = 1; cond_code = 4'(c); tick();
            end
            clr_in();
        end
        tick();

        // Reset between request and result
        write_sr(4'h5);
        for (int i = 0; i < DEPTH + 1; i++) begin
            push = 1; tick();
        end
        clr_in();
        cond_valid = 1; cond_code = 4'd14; tick();
        cond_code = 4'd15;
        #5;
        rst_n = 1'b0;
        #1;
        chk("arst_crv", 8'(cond_result_valid), 8'h0);
        chk("arst_taken", 8'(cond_taken), 8'h0);
        chk("arst_sr", 8'(sr), 8'h0);
        chk("arst_empty", 8'(stack_empty), 8'h1);
        chk("arst_full", 8'(stack_full), 8'h0);
        chk("arst_err", 8'(stack_err), 8'h0);
        tick();
        clr_in();
        chk("rst_hold_crv", 8'(cond_result_valid), 8'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_crv", 8'(cond_result_valid), 8'h0);
        chk("post_rst_sr", 8'(sr), 8'h0);
        chk("post_rst_empty", 8'(stack_empty), 8'h1);
        write_sr(4'h9);
        chk("post_rst_we", 8'(sr), 8'h9);
        tick();

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
